// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller.
//   state_e      : controller states
//   COIN5_VAL    : credit units added by a 5-coin
//   COIN10_VAL   : credit units added by a 10-coin
//   price_slice(): extracts one item's price from a packed price table
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_e;

    localparam logic [1:0] COIN5_VAL  = 2'd1;
    localparam logic [1:0] COIN10_VAL = 2'd2;

    // Price tables are zero-extended to this width before slicing, so one
    // helper covers every legal N_ITEM / CREDIT_W combination.
    localparam int PRICE_TBL_W = 256;

    function automatic logic [15:0] price_slice(
        input logic [PRICE_TBL_W-1:0] tbl,
        input int                     idx,
        input int                     w
    );
        logic [PRICE_TBL_W-1:0] mask;
        mask = (PRICE_TBL_W'(1) << w) - PRICE_TBL_W'(1);
        return 16'((tbl >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/vend_machine_multi_edge_det.sv
// Two-flop capture plus rising-edge detect for W asynchronous level inputs.
//   clk, rst_n : system clock, async active-low reset
//   din        : raw input levels
//   evt        : one-cycle event per rising edge (r1 & ~r2, armed bits only)
// A bit is armed only after it has been sampled low, so an input that is
// already high when reset releases never produces a spurious event.
module edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] evt
);

    logic [W-1:0] r1_q, r1_d;
    logic [W-1:0] r2_q, r2_d;
    logic [W-1:0] arm_q, arm_d;

    always_comb begin
        r1_d  = din;
        r2_d  = r1_q;
        arm_d = arm_q | ~din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q  <= '0;
            r2_q  <= '0;
            arm_q <= '0;
        end else begin
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            arm_q <= arm_d;
        end
    end

    assign evt = r1_q & ~r2_q & arm_q;

endmodule

// File: rtl/vend_machine_multi.sv
// Multi-product vending controller: accepts 5/10 coins, vends one of N_ITEM
// products against a price table, and pays back change one unit per cycle.
//   clk, rst_n   : system clock, async active-low reset
//   coin_5/10    : coin sensor levels (rising edge = one coin)
//   sel          : product buttons (rising edge = one request, lowest wins)
//   cancel       : refund button
//   vend_req/id  : dispense handshake, held until vend_ack
//   vend_ack     : dispenser has taken the product
//   chg_pulse    : one pulse per unit of change/refund
//   coin_reject  : coin(s) not credited this cycle
//   deny         : selection refused, insufficient credit
//   credit       : current credit in units
//   busy         : VEND or CHANGE in progress
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | no credit, waiting for coin (or zero-price selection)
// ST_CREDIT | holding credit, accepting coins / selection / cancel
// ST_VEND   | vend_req asserted, waiting for vend_ack
// ST_CHANGE | returning remaining credit, one unit per cycle
module vend_machine_multi
    import vend_pkg::*;
#(
    parameter int N_ITEM     = 4,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 40,
    parameter logic [N_ITEM*CREDIT_W-1:0] PRICES = {6'd4, 6'd3, 6'd2, 6'd1},
    localparam int ID_W = (N_ITEM > 1) ? $clog2(N_ITEM) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic [N_ITEM-1:0]   sel,
    input  logic                cancel,
    output logic                vend_req,
    output logic [ID_W-1:0]     vend_id,
    input  logic                vend_ack,
    output logic                chg_pulse,
    output logic                coin_reject,
    output logic                deny,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + 2;

    logic [N_ITEM+2:0] evt;
    logic              coin5_evt, coin10_evt, cancel_evt;
    logic [N_ITEM-1:0] sel_evt;

    edge_det #(.W(N_ITEM + 3)) u_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({cancel, sel, coin_10, coin_5}),
        .evt   (evt)
    );

    assign coin5_evt  = evt[0];
    assign coin10_evt = evt[1];
    assign sel_evt    = evt[N_ITEM+1:2];
    assign cancel_evt = evt[N_ITEM+2];

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  vend_req_q, vend_req_d;
    logic [ID_W-1:0]       vend_id_q, vend_id_d;
    logic                  chg_pulse_q, chg_pulse_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  deny_q, deny_d;

    logic [PRICE_TBL_W-1:0] prices_ext;
    logic                   sel_hit;
    logic [ID_W-1:0]        sel_idx;
    logic [CREDIT_W-1:0]    price_sel;
    logic [1:0]             coin_val;
    logic                   coin_any, coin_ok;
    logic [SUM_W-1:0]       credit_sum;
    logic [CREDIT_W-1:0]    credit_after;

    assign prices_ext = PRICE_TBL_W'(PRICES);

    // Lowest-index selection wins: scan downward so the last hit is the lowest.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = N_ITEM - 1; i >= 0; i--) begin
            if (sel_evt[i]) begin
                sel_hit = 1'b1;
                sel_idx = ID_W'(i);
            end
        end
    end

    assign price_sel = CREDIT_W'(price_slice(prices_ext, int'(sel_idx), CREDIT_W));

    // Coins are summed in a wider field so the ceiling check cannot wrap;
    // a rejected cycle rejects every coin seen in it.
    always_comb begin
        coin_val     = (coin5_evt  ? COIN5_VAL  : 2'd0)
                     + (coin10_evt ? COIN10_VAL : 2'd0);
        coin_any     = coin5_evt | coin10_evt;
        credit_sum   = {2'b00, credit_q} + SUM_W'(coin_val);
        coin_ok      = coin_any && (credit_sum <= SUM_W'(MAX_CREDIT));
        credit_after = coin_ok ? credit_sum[CREDIT_W-1:0] : credit_q;
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_req_d    = vend_req_q;
        vend_id_d     = vend_id_q;
        chg_pulse_d   = 1'b0;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                // Same-cycle coins are credited before cancel/select act.
                credit_d = credit_after;
                if (coin_any && !coin_ok) begin
                    coin_reject_d = 1'b1;
                end
                if (coin_ok) begin
                    state_d = ST_CREDIT;
                end
                if (cancel_evt) begin
                    if (credit_after != '0) begin
                        state_d = ST_CHANGE;
                    end
                end else if (sel_hit) begin
                    if (credit_after >= price_sel) begin
                        credit_d   = credit_after - price_sel;
                        vend_id_d  = sel_idx;
                        vend_req_d = 1'b1;
                        state_d    = ST_VEND;
                    end else begin
                        deny_d = 1'b1;
                    end
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_any;
                if (vend_ack) begin
                    vend_req_d = 1'b0;
                    state_d    = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_any;
                if (credit_q != '0) begin
                    chg_pulse_d = 1'b1;
                    credit_d    = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            vend_req_q    <= 1'b0;
            vend_id_q     <= '0;
            chg_pulse_q   <= 1'b0;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_req_q    <= vend_req_d;
            vend_id_q     <= vend_id_d;
            chg_pulse_q   <= chg_pulse_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign vend_id     = vend_id_q;
    assign chg_pulse   = chg_pulse_q;
    assign coin_reject = coin_reject_q;
    assign deny        = deny_q;
    assign credit      = credit_q;
    assign busy        = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vend_machine_multi.sv
// Directed bench for vend_machine_multi with default parameters
// (4 items, prices {4,3,2,1}, MAX_CREDIT 40).
module tb_vend_machine_multi;

    logic       clk;
    logic       rst_n;
    logic [6:0] btn;
    logic       vend_ack;
    logic       vend_req;
    logic [1:0] vend_id;
    logic       chg_pulse;
    logic       coin_reject;
    logic       deny;
    logic [5:0] credit;
    logic       busy;

    localparam logic [6:0] C5  = 7'h01;
    localparam logic [6:0] C10 = 7'h02;
    localparam logic [6:0] S0  = 7'h04;
    localparam logic [6:0] S1  = 7'h08;
    localparam logic [6:0] S2  = 7'h10;
    localparam logic [6:0] S3  = 7'h20;
    localparam logic [6:0] CAN = 7'h40;

    int n_vec = 0;
    int n_err = 0;

    vend_machine_multi dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_5      (btn[0]),
        .coin_10     (btn[1]),
        .sel         (btn[5:2]),
        .cancel      (btn[6]),
        .vend_req    (vend_req),
        .vend_id     (vend_id),
        .vend_ack    (vend_ack),
        .chg_pulse   (chg_pulse),
        .coin_reject (coin_reject),
        .deny        (deny),
        .credit      (credit),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise the given inputs and wait until the DUT has acted on the event.
    task automatic press(input logic [6:0] m);
        btn = m;
        step();
        step();
    endtask

    task automatic rel();
        btn = '0;
        step();
        step();
    endtask

    task automatic count_pulses(input int n, output int cnt, output int first,
                                output int last, output int vreq_seen);
        cnt = 0; first = -1; last = -1; vreq_seen = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (chg_pulse) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
            if (vend_req) vreq_seen = 1;
        end
    endtask

    int cnt, first, last, vseen;

    initial begin
        rst_n = 1'b0;
        btn = '0;
        vend_ack = 1'b0;
        #23;
        chk("rst_credit", credit, 0);
        chk("rst_vend_req", vend_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_chg", chg_pulse, 0);
        step();
        rst_n = 1'b1;
        step(); step();

        // zero credit selection is denied, stray ack ignored
        press(S0);
        chk("idle_deny", deny, 1);
        chk("idle_deny_vreq", vend_req, 0);
        rel();
        chk("deny_one_cycle", deny, 0);
        vend_ack = 1'b1; step(); step(); vend_ack = 1'b0;
        chk("stray_ack_busy", busy, 0);

        // coin_10, coin_5, sel[2] -> exact change vend
        press(C10); chk("s1_credit2", credit, 2); rel();
        press(C5);  chk("s1_credit3", credit, 3); rel();
        press(S2);
        chk("s1_vreq", vend_req, 1);
        chk("s1_vid", vend_id, 2);
        chk("s1_credit0", credit, 0);
        chk("s1_busy", busy, 1);
        rel();
        press(C5);
        chk("s1_vend_coin_rej", coin_reject, 1);
        chk("s1_vend_credit", credit, 0);
        rel();
        press(S1);
        chk("s1_vend_sel_nodeny", deny, 0);
        chk("s1_vreq_held", vend_req, 1);
        chk("s1_vid_held", vend_id, 2);
        rel();
        vend_ack = 1'b1; step(); vend_ack = 1'b0;
        chk("s1_ack_vreq", vend_req, 0);
        chk("s1_ack_busy", busy, 0);
        count_pulses(6, cnt, first, last, vseen);
        chk("s1_no_chg", cnt, 0);

        // 3 x coin_10, sel[0] -> 5 units change
        for (int i = 0; i < 3; i++) begin press(C10); rel(); end
        chk("s2_credit6", credit, 6);
        press(S0);
        chk("s2_vid", vend_id, 0);
        chk("s2_credit5", credit, 5);
        rel();
        vend_ack = 1'b1; step(); vend_ack = 1'b0;
        chk("s2_change_busy", busy, 1);
        count_pulses(12, cnt, first, last, vseen);
        chk("s2_pulses", cnt, 5);
        chk("s2_consecutive", last - first, 4);
        chk("s2_credit0", credit, 0);
        chk("s2_busy_low", busy, 0);

        // coin_5, sel[3] denied, cancel -> 1 pulse
        press(C5); chk("s3_credit1", credit, 1); rel();
        press(S3);
        chk("s3_deny", deny, 1);
        chk("s3_credit1b", credit, 1);
        chk("s3_no_vreq", vend_req, 0);
        rel();
        press(CAN);
        btn = '0;
        count_pulses(8, cnt, first, last, vseen);
        chk("s3_pulses", cnt, 1);
        chk("s3_busy_low", busy, 0);
        chk("s3_credit0", credit, 0);

        // credit ceiling
        for (int i = 0; i < 19; i++) begin press(C10); rel(); end
        press(C5); rel();
        chk("s4_credit39", credit, 39);
        press(C10);
        chk("s4_reject", coin_reject, 1);
        chk("s4_credit_kept", credit, 39);
        rel();
        press(C5);
        chk("s4_credit40", credit, 40);
        chk("s4_no_reject", coin_reject, 0);
        rel();
        press(CAN);
        btn = '0;
        count_pulses(50, cnt, first, last, vseen);
        chk("s4_pulses", cnt, 40);
        chk("s4_credit0", credit, 0);

        // simultaneous coins, cancel beats select
        press(C5 | C10);
        chk("s5_credit3", credit, 3);
        rel();
        press(CAN | S1);
        chk("s5_no_vreq", vend_req, 0);
        chk("s5_busy", busy, 1);
        btn = '0;
        count_pulses(10, cnt, first, last, vseen);
        chk("s5_pulses", cnt, 3);
        chk("s5_never_vreq", vseen, 0);
        chk("s5_credit0", credit, 0);

        // reset during 2nd of 4 change pulses
        press(C10); rel(); press(C10); rel();
        chk("s6_credit4", credit, 4);
        press(CAN);
        btn = '0;
        step();
        chk("s6_pulse1", chg_pulse, 1);
        step();
        chk("s6_pulse2", chg_pulse, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_rst_chg", chg_pulse, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_credit", credit, 0);
        btn = C5;  // held high across reset release
        step(); step();
        rst_n = 1'b1;
        count_pulses(10, cnt, first, last, vseen);
        chk("s6_no_pulses", cnt, 0);
        chk("s6_held_no_credit", credit, 0);
        chk("s6_busy", busy, 0);
        rel();
        press(C5);
        chk("s6_rearm_credit", credit, 1);
        rel();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
